// File: rtl/boron_pkg.sv
// Shared BORON definitions: S-box tables, block shuffle, rotation/XOR layer and FSM states.
package boron_pkg;

  localparam int ROUND_W = 5;
  localparam int BLK_W   = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXPAND = 3'd1,
    ROUND  = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The tables are packed with entry 0 in the least significant nibble.
  localparam logic [63:0] SBOX_TBL     = 64'h6358F02DAC971B4E;
  localparam logic [63:0] INV_SBOX_TBL = 64'hB086275C4FD1E93A;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int n = 0; n < BLK_W/4; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int n = 0; n < BLK_W/4; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    return y;
  endfunction

  // 16-bit word permutation: output word j takes input word {1,3,0,2}[j].
  function automatic logic [BLK_W-1:0] shuffle(input logic [BLK_W-1:0] x);
    return {x[47:32], x[15:0], x[63:48], x[31:16]};
  endfunction

  function automatic logic [BLK_W-1:0] inv_shuffle(input logic [BLK_W-1:0] x);
    return {x[31:16], x[63:48], x[15:0], x[47:32]};
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  // Per-word rotations followed by an XOR chain from word 0 upward.
  function automatic logic [BLK_W-1:0] rotxor(input logic [BLK_W-1:0] x);
    logic [15:0] o0, o1, o2, o3;
    o0 = rol16(x[15:0], 1);
    o1 = rol16(x[31:16], 4) ^ o0;
    o2 = rol16(x[47:32], 7) ^ o1;
    o3 = rol16(x[63:48], 9) ^ o2;
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [BLK_W-1:0] inv_rotxor(input logic [BLK_W-1:0] x);
    logic [15:0] w0, w1, w2, w3;
    w0 = ror16(x[15:0], 1);
    w1 = ror16(x[31:16] ^ x[15:0], 4);
    w2 = ror16(x[47:32] ^ x[31:16], 7);
    w3 = ror16(x[63:48] ^ x[47:32], 9);
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/boron_iter_core_round.sv
// Combinational BORON round. Both directions key-mix first, so the inverse round
// exactly undoes one forward round when fed the next round key in sequence.
module boron_round
  import boron_pkg::*;
(
  input  logic [BLK_W-1:0] blk,
  input  logic [63:0]      rk,
  input  logic             dir,
  output logic [BLK_W-1:0] nxt
);

  logic [BLK_W-1:0] mixed;

  assign mixed = blk ^ rk;

  always_comb begin
    nxt = '0;
    if (dir) nxt = inv_sbox_layer(inv_shuffle(inv_rotxor(mixed)));
    else     nxt = rotxor(shuffle(sbox_layer(mixed)));
  end

endmodule

// File: rtl/boron_iter_core.sv
// Iterative BORON engine, one round per clock, encrypt/decrypt per request.
// Optional BORON_KEY_CACHE_EN keeps the last expanded decrypt key to skip EXPAND.
module boron_iter_core
  import boron_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [KEY_W-1:0] key_in,
  input  logic [63:0]      text_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [63:0]      text_out
);

  generate
    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
      $error("boron_iter_core: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("boron_iter_core: ROUNDS must be 1..31");
    end
  endgenerate

  localparam logic [ROUND_W-1:0] RC_ONE  = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] RC_LAST = ROUND_W'(ROUNDS);

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                               input logic [ROUND_W-1:0] r);
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-14:0], k[KEY_W-1:KEY_W-13]};
    t[3:0] = sbox(t[3:0]);
    if (KEY_W == 128) t[7:4] = sbox(t[7:4]);
    t[63:59] = t[63:59] ^ r;
    return t;
  endfunction

  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                               input logic [ROUND_W-1:0] r);
    logic [KEY_W-1:0] t;
    t = k;
    t[63:59] = t[63:59] ^ r;
    if (KEY_W == 128) t[7:4] = inv_sbox(t[7:4]);
    t[3:0] = inv_sbox(t[3:0]);
    return {t[12:0], t[KEY_W-1:13]};
  endfunction

  state_t             state, nxt_state;
  logic [ROUND_W-1:0] rc;
  logic               dir;
  logic [KEY_W-1:0]   key, key_fwd_nxt, key_inv_nxt, start_key;
  logic [BLK_W-1:0]   blk, round_out;
  logic               accept, last_round, hit;

  assign accept      = (state == IDLE) && start;
  assign last_round  = dir ? (rc == RC_ONE) : (rc == RC_LAST);
  assign key_fwd_nxt = key_fwd(key, rc);
  assign key_inv_nxt = key_inv(key, rc);

`ifdef BORON_KEY_CACHE_EN
  logic             cache_vld;
  logic [KEY_W-1:0] cache_mkey, cache_fkey, mkey;

  assign hit       = mode && cache_vld && (key_in == cache_mkey);
  assign start_key = hit ? cache_fkey : key_in;

  // Filled when EXPAND finishes; mkey remembers which master key is being expanded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld  <= 1'b0;
      cache_mkey <= '0;
      cache_fkey <= '0;
      mkey       <= '0;
    end else begin
      if (accept) mkey <= key_in;
      if (state == EXPAND && rc == RC_LAST) begin
        cache_vld  <= 1'b1;
        cache_mkey <= mkey;
        cache_fkey <= key_fwd_nxt;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign start_key = key_in;
`endif

  boron_round u_round (
    .blk (blk),
    .rk  (key[63:0]),
    .dir (dir),
    .nxt (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (start) nxt_state = (mode && !hit) ? EXPAND : ROUND;
      EXPAND:  if (rc == RC_LAST) nxt_state = ROUND;
      ROUND:   if (last_round) nxt_state = FINAL;
      FINAL:   nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == EXPAND) || (state == ROUND) || (state == FINAL);
    done  = (state == DONE);
  end

  // Decrypt enters ROUND holding the final key with rc=ROUNDS and walks both back down.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc       <= '0;
      dir      <= 1'b0;
      key      <= '0;
      blk      <= '0;
      text_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dir <= mode;
          key <= start_key;
          blk <= text_in;
          rc  <= hit ? RC_LAST : RC_ONE;
        end
        EXPAND: begin
          key <= key_fwd_nxt;
          if (rc != RC_LAST) rc <= rc + RC_ONE;
        end
        ROUND: begin
          blk <= round_out;
          key <= dir ? key_inv_nxt : key_fwd_nxt;
          if (!last_round) rc <= dir ? rc - RC_ONE : rc + RC_ONE;
        end
        FINAL: begin
          text_out <= blk ^ key[63:0];
          rc       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boron_iter_core.sv
// Scoreboard bench for boron_iter_core: 80-bit and 128-bit instances checked against
// a forward-only reference cipher; decrypt expectations are the original plaintexts.
module tb_boron_iter_core;

  localparam int R = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0, mode = 1'b0;
  logic [79:0]  key_in = '0;
  logic [63:0]  text_in = '0;
  logic         ready, busy, done;
  logic [63:0]  text_out;

  logic         start2 = 1'b0, mode2 = 1'b0;
  logic [127:0] key_in2 = '0;
  logic [63:0]  text_in2 = '0;
  logic         ready2, busy2, done2;
  logic [63:0]  text_out2;

  boron_iter_core #(.KEY_W(80), .ROUNDS(R)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in), .text_in(text_in),
    .ready(ready), .busy(busy), .done(done), .text_out(text_out)
  );

  boron_iter_core #(.KEY_W(128), .ROUNDS(R)) u_dut128 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .key_in(key_in2), .text_in(text_in2),
    .ready(ready2), .busy(busy2), .done(done2), .text_out(text_out2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { logic [63:0] res; int acc; int lat; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  logic         cvld [2] = '{1'b0, 1'b0};
  logic [127:0] ckey [2];

  logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                          4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference cipher: rounds of key-mix, S-box, word shuffle, rotate/XOR chain, key update.
  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [127:0] key,
                                            input int kw);
    logic [127:0] k, mask;
    logic [63:0]  s;
    logic [15:0]  w [4];
    logic [15:0]  o [4];
    logic [15:0]  r;
    int SH  [4] = '{1, 3, 0, 2};
    int ROT [4] = '{1, 4, 7, 9};
    mask = (kw == 128) ? {128{1'b1}} : ((128'd1 << kw) - 128'd1);
    k = key & mask;
    s = pt;
    for (int i = 1; i <= R; i++) begin
      s = s ^ k[63:0];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      for (int j = 0; j < 4; j++) w[j] = s[16*j +: 16];
      for (int j = 0; j < 4; j++) begin
        r = (w[SH[j]] << ROT[j]) | (w[SH[j]] >> (16 - ROT[j]));
        if (j == 0) o[j] = r;
        else        o[j] = r ^ o[j-1];
      end
      s = {o[3], o[2], o[1], o[0]};
      k = ((k << 13) | (k >> (kw - 13))) & mask;
      k[3:0] = SB[k[3:0]];
      if (kw == 128) k[7:4] = SB[k[7:4]];
      k[63:59] = k[63:59] ^ 5'(i);
    end
    return s ^ k[63:0];
  endfunction

  function automatic logic [127:0] rand_key(input int kw);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    if (kw == 80) k[127:80] = '0;
    return k;
  endfunction

  // Issues one request once the selected core is ready; always returns at a negedge.
  task automatic issue(input int sel, input logic m, input logic [127:0] k,
                       input logic [63:0] t, input logic [63:0] res, input bit track);
    int n = 0;
    int lat;
    bit hit = 1'b0;
    while (!(sel != 0 ? ready2 : ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(sel != 0 ? ready2 : ready)) begin
      chk("ready_timeout", 64'(sel != 0 ? ready2 : ready), 64'd1);
      return;
    end
`ifdef BORON_KEY_CACHE_EN
    if (m) begin
      hit = cvld[sel] && (ckey[sel] == k);
      cvld[sel] = 1'b1;
      ckey[sel] = k;
    end
`endif
    lat = (m && !hit) ? 2*R + 2 : R + 2;
    if (track) begin
      if (sel != 0) q2.push_back('{res, cyc + 1, lat});
      else          q1.push_back('{res, cyc + 1, lat});
    end
    if (sel != 0) begin
      start2 = 1'b1; mode2 = m; key_in2 = k; text_in2 = t;
    end else begin
      start = 1'b1; mode = m; key_in = k[79:0]; text_in = t;
    end
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q1.size() + q2.size()), 64'd0);
  endtask

  logic dp1 = 1'b0, rp1 = 1'b0, dp2 = 1'b0, rp2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      dp1 = 1'b0;
      rp1 = 1'b0;
    end else begin
      if (rp1) chk("ready_after_done", 64'(ready), 64'd1);
      rp1 = 1'b0;
      if (done) begin
        chk("done_one_cycle", 64'(dp1), 64'd0);
        if (q1.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("text_out", text_out, e1.res);
          chk("latency", 64'(cyc - e1.acc + 1), 64'(e1.lat));
        end
        rp1 = 1'b1;
      end
      dp1 = done;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      dp2 = 1'b0;
      rp2 = 1'b0;
    end else begin
      if (rp2) chk("ready_after_done_128", 64'(ready2), 64'd1);
      rp2 = 1'b0;
      if (done2) begin
        chk("done_one_cycle_128", 64'(dp2), 64'd0);
        if (q2.size() == 0) chk("done_unexpected_128", 64'(done2), 64'd0);
        else begin
          e2 = q2.pop_front();
          chk("text_out_128", text_out2, e2.res);
          chk("latency_128", 64'(cyc - e2.acc + 1), 64'(e2.lat));
        end
        rp2 = 1'b1;
      end
      dp2 = done2;
    end
  end

  initial begin
    logic [127:0] k;
    logic [63:0]  pt, ct;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_text_out", text_out, 64'd0);
    chk("reset_ready_128", 64'(ready2), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Known-vector round trips.
    pt = 64'h08afaa49b773bd03; k = 128'(80'h497c41fec3b69bcbf171);
    ct = model_enc(pt, k, 80);
    issue(0, 1'b0, k, pt, ct, 1'b1);
    issue(0, 1'b1, k, ct, pt, 1'b1);
    drain();
    pt = 64'h3bd8f07913e117f4; k = 128'(80'hef0e726f2fc5c524d10a);
    ct = model_enc(pt, k, 80);
    issue(0, 1'b0, k, pt, ct, 1'b1);
    issue(0, 1'b1, k, ct, pt, 1'b1);
    drain();

    // start hammered while busy must be ignored.
    k = rand_key(80); pt = {$urandom, $urandom};
    ct = model_enc(pt, k, 80);
    issue(0, 1'b0, k, pt, ct, 1'b1);
    repeat (20) begin
      start = 1'b1; mode = 1'($urandom);
      key_in = rand_key(80)[79:0]; text_in = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("text_out_hold", text_out, ct);

    // Random back-to-back traffic; keys repeat so a cache build sees hits.
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) k = rand_key(80);
      pt = {$urandom, $urandom};
      ct = model_enc(pt, k, 80);
      issue(0, 1'b0, k, pt, ct, 1'b1);
      issue(0, 1'b1, k, ct, pt, 1'b1);
    end
    drain();

    // Two decrypts under one fresh key.
    k = rand_key(80); pt = {$urandom, $urandom};
    ct = model_enc(pt, k, 80);
    issue(0, 1'b1, k, ct, pt, 1'b1);
    issue(0, 1'b1, k, ct, pt, 1'b1);
    drain();

    // Abort at round 10: no done may follow.
    k = rand_key(80); pt = {$urandom, $urandom};
    issue(0, 1'b0, k, pt, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_text_out", text_out, 64'd0);
    rst = 1'b0;
    cvld[0] = 1'b0;
    cvld[1] = 1'b0;
    repeat (60) @(negedge clk);

    // 128-bit key instance.
    k = '0; pt = 64'hffffffffffffffff;
    ct = model_enc(pt, k, 128);
    issue(1, 1'b0, k, pt, ct, 1'b1);
    issue(1, 1'b1, k, ct, pt, 1'b1);
    k = rand_key(128); pt = {$urandom, $urandom};
    ct = model_enc(pt, k, 128);
    issue(1, 1'b0, k, pt, ct, 1'b1);
    issue(1, 1'b1, k, ct, pt, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
